// File: rtl/sadd_arb_pkg.sv
// Shared constants for the signed-add arbiter: default geometry, id width helper
// and overflow counter sizing.
package sadd_arb_pkg;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_W       = 4;
    localparam int unsigned OVF_CNT_W   = 8;
    localparam int unsigned OVF_CNT_MAX = 255;

    // Width of a requester index; never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $unsigned($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/sadd_ovf_core.sv
// Combinational W-bit two's complement adder with signed overflow detection.
module sadd_ovf_core
    import sadd_arb_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         overflow
);

    // Sum wraps modulo 2^W.
    assign sum = a + b;

    // Overflow: operands agree in sign but the result does not.
    assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/signed_add_arbiter.sv
// Round-robin arbiter sharing one signed adder among N_REQ requesters, with a
// single-entry result register and a saturating overflow counter.
module signed_add_arbiter
    import sadd_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = DEF_N_REQ,
    parameter  int unsigned W     = DEF_W,
    localparam int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*W-1:0]     req_a,
    input  logic [N_REQ*W-1:0]     req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [W-1:0]           res_sum,
    output logic                   res_overflow,
    output logic [OVF_CNT_W-1:0]   ovf_count
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            load_ok;
    logic            accept;
    logic            drain;
    logic [W-1:0]    a_arr [N_REQ];
    logic [W-1:0]    b_arr [N_REQ];
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    core_sum;
    logic            core_ovf;

    // Unpack the flat operand buses into per-requester lanes.
    for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*W +: W];
        assign b_arr[gi] = req_b[gi*W +: W];
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The result register can take a new value when empty or being drained.
    assign load_ok = !res_valid || res_ready;
    assign drain   = res_valid && res_ready;

    // One-hot ready to the winner only; forced low while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && load_ok && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Steer the winner's operands into the shared adder.
    assign op_a = a_arr[grant_idx];
    assign op_b = b_arr[grant_idx];

    sadd_ovf_core #(
        .W (W)
    ) u_core (
        .a        (op_a),
        .b        (op_b),
        .sum      (core_sum),
        .overflow (core_ovf)
    );

    // Priority pointer follows the last accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

    // Result register: load on accept, clear on drain, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_sum      <= '0;
            res_overflow <= 1'b0;
        end else if (accept) begin
            res_valid    <= 1'b1;
            res_id       <= grant_idx;
            res_sum      <= core_sum;
            res_overflow <= core_ovf;
        end else if (res_ready) begin
            res_valid    <= 1'b0;
        end
    end

    // Count delivered overflowing results, saturating at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (drain && res_overflow &&
                     (ovf_count != OVF_CNT_W'(OVF_CNT_MAX))) begin
            ovf_count <= ovf_count + OVF_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Bench for signed_add_arbiter: table vectors, directed corner sequences and a
// random run checked against a cycle model plus per-requester scoreboards.
module tb_signed_add_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [1:0]     res_id;
    logic [W-1:0]   res_sum;
    logic           res_overflow;
    logic [7:0]     ovf_count;

    signed_add_arbiter #(
        .N_REQ (N),
        .W     (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_sum      (res_sum),
        .res_overflow (res_overflow),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int         m_ptr;
    logic       m_rv;
    int         m_id;
    logic [3:0] m_sum;
    logic       m_ovf;
    int         m_cnt;
    logic [7:0] sbq [N][$];
    logic [N-1:0] last_rdy;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Signed addition with plain integer arithmetic.
    function automatic void ref_add(input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] s, output logic o);
        int x;
        x = int'($signed(a)) + int'($signed(b));
        o = (x > 7) || (x < -8);
        s = 4'(x);
    endfunction

    function automatic int m_grant();
        for (int k = 1; k <= int'(N); k++) begin
            int i;
            i = (m_ptr + k) % int'(N);
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    // One clock: check ready before the edge, advance the model, check results after.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        logic [3:0] a, b, s;
        logic o;
        logic [7:0] op;
        #1;
        g = m_grant();
        exp_rdy = '0;
        if (g >= 0 && (!m_rv || res_ready)) exp_rdy = N'(1) << g;
        last_rdy = req_ready;
        check("req_ready", int'(req_ready), int'(exp_rdy));
        if (m_rv && res_ready) begin
            check("sb_nonempty", int'(sbq[m_id].size() != 0), 1);
            if (sbq[m_id].size() != 0) begin
                op = sbq[m_id].pop_front();
                ref_add(op[3:0], op[7:4], s, o);
                check("sb_sum", int'(res_sum), int'(s));
                check("sb_ovf", int'(res_overflow), int'(o));
            end
            if (m_ovf && m_cnt < 255) m_cnt++;
        end
        if (exp_rdy != '0) begin
            a = req_a[g*4 +: 4];
            b = req_b[g*4 +: 4];
            ref_add(a, b, s, o);
            m_rv  = 1'b1;
            m_id  = g;
            m_sum = s;
            m_ovf = o;
            m_ptr = g;
            sbq[g].push_back({b, a});
        end else if (res_ready) begin
            m_rv = 1'b0;
        end
        @(posedge clk);
        #1;
        check("res_valid", int'(res_valid), int'(m_rv));
        if (m_rv) begin
            check("res_id", int'(res_id), m_id);
            check("res_sum", int'(res_sum), int'(m_sum));
            check("res_overflow", int'(res_overflow), int'(m_ovf));
        end
        check("ovf_count", int'(ovf_count), m_cnt);
    endtask

    // Assert reset asynchronously, check outputs before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_res_sum", int'(res_sum), 0);
        check("rst_res_ovf", int'(res_overflow), 0);
        check("rst_ovf_count", int'(ovf_count), 0);
        check("rst_req_ready", int'(req_ready), 0);
        m_ptr = int'(N) - 1;
        m_rv  = 1'b0;
        m_id  = 0;
        m_sum = '0;
        m_ovf = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < int'(N); i++) sbq[i].delete();
        @(posedge clk);
        check("rst_req_ready_held", int'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pc;
        logic [N-1:0] last_acc;

        vecs = '{
            '{4'd4,  4'd7,  4'b1011, 1'b1},
            '{4'hD,  4'hB,  4'b1000, 1'b0},
            '{4'hC,  4'h9,  4'b0101, 1'b1},
            '{4'h1,  4'hE,  4'b1111, 1'b0},
            '{4'h7,  4'h7,  4'b1110, 1'b1},
            '{4'h8,  4'h8,  4'b0000, 1'b1},
            '{4'h8,  4'h7,  4'b1111, 1'b0},
            '{4'h3,  4'h4,  4'b0111, 1'b0},
            '{4'hF,  4'h1,  4'b0000, 1'b0}
        };

        do_reset();

        // Table: single requester 0, immediate drain
        res_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_valid = 4'b0001;
            set_op(0, vecs[i].a, vecs[i].b);
            cycle();
            check("tbl_id", int'(res_id), 0);
            check("tbl_sum", int'(res_sum), int'(vecs[i].sum));
            check("tbl_ovf", int'(res_overflow), int'(vecs[i].ovf));
            req_valid = '0;
            cycle();
            if (i == 0) check("ovf_first_drain", int'(ovf_count), 1);
        end

        // Mid-stream asynchronous reset with a result pending
        set_op(0, 4'hD, 4'hB);
        set_op(1, 4'hC, 4'h9);
        set_op(2, 4'h1, 4'hE);
        set_op(3, 4'h7, 4'h7);
        req_valid = 4'b1111;
        cycle();
        cycle();
        check("pre_rst_valid", int'(res_valid), 1);
        #2;
        do_reset();

        // All requesters valid: rotation 0,1,2,3,... at full throughput
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k == 0) check("first_after_rst", int'(last_rdy), 1);
            check("rr_id", int'(res_id), k % 4);
            check("rr_valid", int'(res_valid), 1);
            if (k % 4 == 0) begin
                check("rr_sum_m8", int'(res_sum), 8);
                check("rr_ovf0", int'(res_overflow), 0);
            end
            if (k % 4 == 1) check("rr_ovf1", int'(res_overflow), 1);
        end

        // Stall with (1,-2) pending, then release
        req_valid = '0;
        cycle();
        req_valid = 4'b0100;
        res_ready = 1'b0;
        cycle();
        check("stall_sum", int'(res_sum), 15);
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_ready", int'(last_rdy), 0);
            check("stall_hold_sum", int'(res_sum), 15);
            check("stall_hold_id", int'(res_id), 2);
        end
        res_ready = 1'b1;
        cycle();
        check("release_grant", int'(last_rdy), 8);
        check("release_id", int'(res_id), 3);

        // Saturate the overflow counter
        req_valid = 4'b0001;
        set_op(0, 4'h7, 4'h7);
        repeat (300) cycle();
        req_valid = '0;
        cycle();
        check("ovf_sat", int'(ovf_count), 255);
        req_valid = 4'b0001;
        repeat (5) cycle();
        req_valid = '0;
        cycle();
        check("ovf_sat_hold", int'(ovf_count), 255);

        // Random valid/ready traffic walking all operand pairs
        pc = 0;
        last_acc = '0;
        for (int c = 0; c < 2000; c++) begin
            res_ready = ($urandom_range(9) < 7);
            for (int i = 0; i < int'(N); i++) begin
                if (!req_valid[i] || last_acc[i]) begin
                    if ($urandom_range(9) < 6) begin
                        req_valid[i] = 1'b1;
                        set_op(i, 4'(pc), 4'(pc >> 4));
                        pc++;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(9) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
            last_acc = last_rdy & req_valid;
        end
        req_valid = '0;
        res_ready = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < int'(N); i++) check("sb_left", sbq[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
